// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: operand/shift widths and the shifter stage record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//    ALU_DATA_W    - default operand width
//    ALU_SHAMT_W   - default shift-amount width (log2 of ALU_DATA_W)
//    shift_stage_t - contents of one right-shifter pipeline stage
package alu_pkg;

   localparam int ALU_DATA_W  = 32;
   localparam int ALU_SHAMT_W = 5;

   typedef struct packed {
      logic                   valid;
      logic                   arith;
      logic [ALU_SHAMT_W-1:0] shamt;
      logic [ALU_DATA_W-1:0]  data;
   } shift_stage_t;

endpackage

// File: rtl/bar_shift_stage.sv
// One stage of the pipelined right shifter: conditional fixed-distance shift plus stage register.
// Latency: 1 cycle when i_en is high.
// Backpressure: i_en low freezes the stage register (valid, data, shamt, arith).
//
// Ports:
//    clk, rst_n                      - clock, async active-low reset
//    i_en                            - load enable (global pipeline advance)
//    i_valid/i_data/i_shamt/i_arith  - predecessor stage contents
//    o_valid/o_data/o_shamt/o_arith  - this stage's registered contents
// Sign fill is built only when BAR_SHIFTER_ARITH_EN is defined; otherwise fill is
// always zero, i_arith is ignored and o_arith reads 0.
module bar_shift_stage #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5,
   parameter int SHIFT   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_en,
   input  logic               i_valid,
   input  logic [DATA_W-1:0]  i_data,
   input  logic [SHAMT_W-1:0] i_shamt,
   input  logic               i_arith,
   output logic               o_valid,
   output logic [DATA_W-1:0]  o_data,
   output logic [SHAMT_W-1:0] o_shamt,
   output logic               o_arith
);

   // shamt bit that selects this stage's shift distance
   localparam int BIT = $clog2(SHIFT);

   logic [SHIFT-1:0]   w_fill;
   logic [DATA_W-1:0]  w_next;

   logic               r_valid;
   logic [DATA_W-1:0]  r_data;
   logic [SHAMT_W-1:0] r_shamt;

`ifdef BAR_SHIFTER_ARITH_EN
   logic               r_arith;

   // Sign is taken from this stage's input; earlier stages already replicated it,
   // so the chained result equals one arithmetic shift.
   assign w_fill = i_arith ? {SHIFT{i_data[DATA_W-1]}} : '0;
`else
   logic               w_unused;

   assign w_fill   = '0;
   assign w_unused = i_arith;
`endif

   assign w_next = i_shamt[BIT] ? {w_fill, i_data[DATA_W-1:SHIFT]} : i_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_shamt <= '0;
      end else if (i_en) begin
         r_valid <= i_valid;
         r_data  <= w_next;
         r_shamt <= i_shamt;
      end
   end

`ifdef BAR_SHIFTER_ARITH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arith <= 1'b0;
      end else if (i_en) begin
         r_arith <= i_arith;
      end
   end

   assign o_arith = r_arith;
`else
   assign o_arith = 1'b0;
`endif

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_shamt = r_shamt;

endmodule

// File: rtl/bar_shifter_right_pipe.sv
// Pipelined right barrel shifter (SRL/SRA), stages shift by 16,8,4,2,1 at the default width.
// Latency: SHAMT_W cycles input transfer to out_valid, one op per cycle.
// Backpressure: whole pipe stalls when out_valid && !out_ready; in_ready drops in the same cycle.
//
// Ports:
//    clk, rst_n                           - clock, async active-low reset
//    in_valid/in_ready                    - input handshake
//    in_data/in_shamt/in_arith            - operand, right-shift amount, sign-fill select
//    out_valid/out_ready/out_data         - output handshake and result (straight from last stage)
// Optional feature macro: BAR_SHIFTER_ARITH_EN (sign fill; without it in_arith is ignored).
module bar_shifter_right_pipe
   import alu_pkg::*;
#(
   parameter  int DATA_W  = ALU_DATA_W,
   localparam int SHAMT_W = $clog2(DATA_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic               in_arith,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data
);

   // Index 0 is the input port; index s is the register of stage s.
   logic [SHAMT_W:0]              w_valid;
   logic [SHAMT_W:0][DATA_W-1:0]  w_data;
   logic [SHAMT_W:0][SHAMT_W-1:0] w_shamt;
   logic [SHAMT_W:0]              w_arith;
   logic                          w_adv;
   logic                          w_unused;

   // One global enable: the pipe only moves when the last stage can be vacated.
   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   assign w_valid[0] = in_valid;
   assign w_data[0]  = in_data;
   assign w_shamt[0] = in_shamt;
   assign w_arith[0] = in_arith;

   for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      bar_shift_stage #(
         .DATA_W  (DATA_W),
         .SHAMT_W (SHAMT_W),
         .SHIFT   (1 << (SHAMT_W - 1 - gi))
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_en    (w_adv),
         .i_valid (w_valid[gi]),
         .i_data  (w_data[gi]),
         .i_shamt (w_shamt[gi]),
         .i_arith (w_arith[gi]),
         .o_valid (w_valid[gi+1]),
         .o_data  (w_data[gi+1]),
         .o_shamt (w_shamt[gi+1]),
         .o_arith (w_arith[gi+1])
      );
   end

   assign out_valid = w_valid[SHAMT_W];
   assign out_data  = w_data[SHAMT_W];

   // Control fields of the last stage have no consumer.
   assign w_unused = ^{w_shamt[SHAMT_W], w_arith[SHAMT_W]};

endmodule

// File: tb/tb_bar_shifter_right_pipe.sv
// Directed and randomised bench for bar_shifter_right_pipe at the default 32-bit width.
// Latency: checks the 5-cycle result latency and FIFO ordering.
// Backpressure: drives out_ready stalls and checks in_ready and held output data.
module tb_bar_shifter_right_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic        in_arith;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   int n_cmp  = 0;
   int n_fail = 0;

   bar_shifter_right_pipe #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_arith  (in_arith),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Reference: plain >> or >>> on the whole operand.
   function automatic logic [31:0] shr_model(input logic [31:0] d, input logic [4:0] s,
                                             input logic a);
      logic signed [31:0] sd;
      logic               use_sign;
      sd = d;
`ifdef BAR_SHIFTER_ARITH_EN
      use_sign = a;
`else
      use_sign = 1'b0 & a;
`endif
      if (use_sign) begin
         return sd >>> s;
      end
      return d >> s;
   endfunction

   // One isolated operation with out_ready high; checks latency and result.
   task automatic run_one(input string tag, input logic [31:0] d, input logic [4:0] s,
                          input logic a, input logic [31:0] exp, input logic check_pulse);
      int lat;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      in_arith = a;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk32({tag, " latency"}, 32'(lat), 32'd5);
      chk32({tag, " data"}, out_data, exp);
      if (check_pulse) begin
         @(negedge clk);
         chk1({tag, " single pulse"}, out_valid, 1'b0);
      end
   endtask

   initial begin
      int          c;
      int          idx;
      int          rx;
      int          hits;
      int          n_in;
      int          n_out;
      int          cyc;
      logic        acc;
      logic [31:0] exp_v;
      logic [31:0] q[$];

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_arith  = 1'b0;
      out_ready = 1'b1;

      // Reset state
      #1;
      chk1("reset out_valid", out_valid, 1'b0);
      chk32("reset out_data", out_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk1("post-reset in_ready", in_ready, 1'b1);
      chk1("post-reset out_valid", out_valid, 1'b0);

      // Pass-through and logical shifts
      run_one("pass shamt0", 32'h8000_0001, 5'd0, 1'b0, 32'h8000_0001, 1'b1);
      run_one("srl 4", 32'hF000_0000, 5'd4, 1'b0, 32'h0F00_0000, 1'b0);
      run_one("srl 16", 32'hFFFF_FFFF, 5'd16, 1'b0, 32'h0000_FFFF, 1'b0);
      run_one("srl 31", 32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001, 1'b0);
      run_one("srl 1", 32'hAAAA_AAAA, 5'd1, 1'b0, 32'h5555_5555, 1'b0);

      // Arithmetic control
`ifdef BAR_SHIFTER_ARITH_EN
      run_one("sra 31 neg", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0);
      run_one("sra 12 neg", 32'h8123_4567, 5'd12, 1'b1, 32'hFFF8_1234, 1'b0);
`else
      run_one("arith ignored 31", 32'h8000_0000, 5'd31, 1'b1, 32'h0000_0001, 1'b0);
      run_one("arith ignored 12", 32'h8123_4567, 5'd12, 1'b1, 32'h0008_1234, 1'b0);
`endif
      run_one("arith0 31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b0);
      run_one("sra 4 pos", 32'h7000_0000, 5'd4, 1'b1, 32'h0700_0000, 1'b0);
      run_one("sra 0 neg", 32'h8000_0001, 5'd0, 1'b1, 32'h8000_0001, 1'b0);

      // Backpressure: 8 back-to-back ops, out_ready low on stream cycles 6..8
      @(negedge clk);
      idx = 0;
      rx  = 0;
      c   = 0;
      while (rx < 8 && c < 60) begin
         out_ready = !(c >= 6 && c <= 8);
         if (idx < 8) begin
            in_valid = 1'b1;
            in_data  = 32'hFFFF_FFFF;
            in_shamt = idx[4:0];
            in_arith = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         chk1("bp in_ready", in_ready, !(c >= 6 && c <= 8));
         if (out_valid) begin
            exp_v = 32'hFFFF_FFFF >> rx;
            chk32("bp data/order", out_data, exp_v);
         end
         if (out_valid && out_ready) rx++;
         if (in_valid && in_ready) idx++;
         @(negedge clk);
         c++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk32("bp results delivered", 32'(rx), 32'd8);

      // Reset mid-flight: hold a result at the output, then pulse reset
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 32'h1234_5678 + 32'(k);
         in_shamt = 5'(k);
         in_arith = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      c = 0;
      while (!out_valid && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk1("rst precondition out_valid", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk1("rst async out_valid", out_valid, 1'b0);
      chk32("rst async out_data", out_data, 32'h0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      hits = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid) hits++;
      end
      chk32("rst no stale results", 32'(hits), 32'd0);
      chk1("rst in_ready", in_ready, 1'b1);

      // Random traffic against the reference model
      n_in  = 0;
      n_out = 0;
      cyc   = 0;
      acc   = 1'b1;
      while (n_out < 3000 && cyc < 40000) begin
         if (acc || !in_valid) begin
            if (n_in < 3000) begin
               in_valid = 1'($urandom_range(0, 3) != 0);
               in_data  = $urandom;
               in_shamt = 5'($urandom_range(0, 31));
               in_arith = 1'($urandom_range(0, 1));
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = 1'($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            chk1("rnd result expected", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
               exp_v = q.pop_front();
               chk32("rnd data/order", out_data, exp_v);
            end
            n_out++;
         end
         acc = in_valid && in_ready;
         if (acc) begin
            q.push_back(shr_model(in_data, in_shamt, in_arith));
            n_in++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk32("rnd all results", 32'(n_out), 32'd3000);
      chk32("rnd scoreboard empty", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
